// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder/subtractor: one digit per clock, least significant digit first.
// A request is latched in IDLE, ripples through RUN for DIGITS cycles, and is published in DONE.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  inp_clk,
    input  logic                  inp_rst,
    input  logic                  inp_valid,
    output logic                  out_ready,
    input  logic [4*DIGITS-1:0]   inp_A,
    input  logic [4*DIGITS-1:0]   inp_B,
    input  logic                  inp_cin,
    input  logic                  inp_sub,
    output logic [4*DIGITS-1:0]   out_ans,
    output logic                  out_carry,
    output logic                  out_err,
    output logic                  out_valid
);

    localparam int W    = 4 * DIGITS;
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic digit_bad(input logic [3:0] d);
        return (d > 4'd9);
    endfunction

    // Returns {carry, digit}; subtract uses the 9's complement of b, wrapping mod 16 for illegal digits.
    function automatic logic [4:0] digit_step(input logic [3:0] a, input logic [3:0] b,
                                              input logic sub, input logic c);
        logic [3:0] bp;
        logic [4:0] z;
        logic [4:0] zc;
        bp = sub ? (4'd9 - b) : b;
        z  = {1'b0, a} + {1'b0, bp} + {4'd0, c};
        zc = z + 5'd6;
        if (z > 5'd9) begin
            return {1'b1, zc[3:0]};
        end else begin
            return {1'b0, z[3:0]};
        end
    endfunction

    state_t            state_q,     state_d;
    logic [IDXW-1:0]   idx_q,       idx_d;
    logic [W-1:0]      a_q,         a_d;
    logic [W-1:0]      b_q,         b_d;
    logic              sub_q,       sub_d;
    logic              carry_q,     carry_d;
    logic              err_acc_q,   err_acc_d;
    logic [W-1:0]      res_q,       res_d;
    logic [W-1:0]      out_ans_q,   out_ans_d;
    logic              out_carry_q, out_carry_d;
    logic              out_err_q,   out_err_d;
    logic              out_valid_q, out_valid_d;
    logic              out_ready_q, out_ready_d;

    logic [4:0]        step_s;
    logic [W-1:0]      res_next_s;
    logic              bad_s;

    // Next-state and datapath: operands shift right so the active digit is always in bits [3:0].
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        sub_d       = sub_q;
        carry_d     = carry_q;
        err_acc_d   = err_acc_q;
        res_d       = res_q;
        out_ans_d   = out_ans_q;
        out_carry_d = out_carry_q;
        out_err_d   = out_err_q;
        out_valid_d = 1'b0;
        out_ready_d = out_ready_q;

        step_s     = digit_step(a_q[3:0], b_q[3:0], sub_q, carry_q);
        res_next_s = (res_q >> 3'd4) | (W'(step_s[3:0]) << (W - 4));
        bad_s      = digit_bad(a_q[3:0]) | digit_bad(b_q[3:0]);

        case (state_q)
            ST_IDLE: begin
                out_ready_d = 1'b1;
                if (inp_valid) begin
                    a_d         = inp_A;
                    b_d         = inp_B;
                    sub_d       = inp_sub;
                    carry_d     = inp_sub ? 1'b1 : inp_cin;
                    idx_d       = {IDXW{1'b0}};
                    err_acc_d   = 1'b0;
                    res_d       = {W{1'b0}};
                    out_ready_d = 1'b0;
                    state_d     = ST_RUN;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_RUN: begin
                out_ready_d = 1'b0;
                a_d         = a_q >> 3'd4;
                b_d         = b_q >> 3'd4;
                carry_d     = step_s[4];
                err_acc_d   = err_acc_q | bad_s;
                res_d       = res_next_s;
                if (idx_q == LAST_IDX) begin
                    out_ans_d   = res_next_s;
                    out_carry_d = step_s[4];
                    out_err_d   = err_acc_q | bad_s;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    idx_d       = idx_q + IDX_ONE;
                end
            end
            ST_DONE: begin
                out_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                out_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge inp_clk or posedge inp_rst) begin
        if (inp_rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= {IDXW{1'b0}};
            a_q         <= {W{1'b0}};
            b_q         <= {W{1'b0}};
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            err_acc_q   <= 1'b0;
            res_q       <= {W{1'b0}};
            out_ans_q   <= {W{1'b0}};
            out_carry_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            carry_q     <= carry_d;
            err_acc_q   <= err_acc_d;
            res_q       <= res_d;
            out_ans_q   <= out_ans_d;
            out_carry_q <= out_carry_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
            out_ready_q <= out_ready_d;
        end
    end

    assign out_ready = out_ready_q;
    assign out_ans   = out_ans_q;
    assign out_carry = out_carry_q;
    assign out_err   = out_err_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder: three instances (DIGITS = 1, 4, 8) share clock, reset and operands.
module tb_bcd_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  vld;
    logic [31:0] a_in, b_in;
    logic        cin_in, sub_in;
    logic [2:0]  rdy, cy, er, ov;
    logic [3:0]  ans1;
    logic [15:0] ans4;
    logic [31:0] ans8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_serial_adder #(.DIGITS(1)) u_d1 (
        .inp_clk(clk), .inp_rst(rst), .inp_valid(vld[0]), .out_ready(rdy[0]),
        .inp_A(a_in[3:0]), .inp_B(b_in[3:0]), .inp_cin(cin_in), .inp_sub(sub_in),
        .out_ans(ans1), .out_carry(cy[0]), .out_err(er[0]), .out_valid(ov[0]));

    bcd_serial_adder #(.DIGITS(4)) u_d4 (
        .inp_clk(clk), .inp_rst(rst), .inp_valid(vld[1]), .out_ready(rdy[1]),
        .inp_A(a_in[15:0]), .inp_B(b_in[15:0]), .inp_cin(cin_in), .inp_sub(sub_in),
        .out_ans(ans4), .out_carry(cy[1]), .out_err(er[1]), .out_valid(ov[1]));

    bcd_serial_adder #(.DIGITS(8)) u_d8 (
        .inp_clk(clk), .inp_rst(rst), .inp_valid(vld[2]), .out_ready(rdy[2]),
        .inp_A(a_in), .inp_B(b_in), .inp_cin(cin_in), .inp_sub(sub_in),
        .out_ans(ans8), .out_carry(cy[2]), .out_err(er[2]), .out_valid(ov[2]));

    function automatic logic [31:0] get_ans(input int s);
        case (s)
            0:       return {28'd0, ans1};
            1:       return {16'd0, ans4};
            default: return ans8;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request on instance s; returns at the negedge of the DONE cycle.
    task automatic do_op(input int s, input logic [31:0] a, input logic [31:0] b,
                         input logic su, input logic ci, input logic [31:0] ea,
                         input logic ec, input logic ee, input string tag);
        int digs;
        int n;
        digs = (s == 0) ? 1 : ((s == 1) ? 4 : 8);
        @(negedge clk);
        check({tag, "/idle_ready"}, {31'd0, rdy[s]}, 32'd1);
        check({tag, "/idle_novalid"}, {31'd0, ov[s]}, 32'd0);
        a_in = a; b_in = b; sub_in = su; cin_in = ci; vld[s] = 1'b1;
        @(posedge clk);
        #1;
        vld[s] = 1'b0;
        a_in = 32'h9A9A9A9A; b_in = ~b; sub_in = ~su; cin_in = ~ci;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ov[s]) begin
                n = i;
                break;
            end
        end
        check({tag, "/latency"}, 32'(n), 32'(digs + 1));
        check({tag, "/ans"}, get_ans(s), ea);
        check({tag, "/carry"}, {31'd0, cy[s]}, {31'd0, ec});
        check({tag, "/err"}, {31'd0, er[s]}, {31'd0, ee});
        check({tag, "/done_ready"}, {31'd0, rdy[s]}, 32'd0);
    endtask

    initial begin
        int low, vcnt, vidx;
        logic [15:0] got;

        rst = 1'b1; vld = 3'b000; a_in = 32'd0; b_in = 32'd0; cin_in = 1'b0; sub_in = 1'b0;
        repeat (2) @(negedge clk);
        check("reset/ready", {29'd0, rdy}, 32'h7);
        check("reset/valid", {29'd0, ov}, 32'h0);
        check("reset/carry_err", {26'd0, cy, er}, 32'h0);
        check("reset/ans4", {16'd0, ans4}, 32'h0);
        check("reset/ans8", ans8, 32'h0);
        rst = 1'b0;

        // DIGITS=4 main function and corner cases
        do_op(1, 32'h1234, 32'h5678, 1'b0, 1'b0, 32'h6912, 1'b0, 1'b0, "d4_add");
        do_op(1, 32'h9999, 32'h0000, 1'b0, 1'b1, 32'h0000, 1'b1, 1'b0, "d4_wrap");
        do_op(1, 32'h5000, 32'h1234, 1'b1, 1'b0, 32'h3766, 1'b1, 1'b0, "d4_sub");
        do_op(1, 32'h0100, 32'h0250, 1'b1, 1'b1, 32'h9850, 1'b0, 1'b0, "d4_borrow");
        do_op(1, 32'h00A0, 32'h0001, 1'b0, 1'b0, 32'h0101, 1'b0, 1'b1, "d4_errA");

        // Request pulsed during RUN must be ignored; out_ans holds until DONE
        @(negedge clk);
        a_in = 32'h1234; b_in = 32'h5678; sub_in = 1'b0; cin_in = 1'b0; vld[1] = 1'b1;
        @(posedge clk);
        #1;
        vld[1] = 1'b0;
        low = 0; vcnt = 0; vidx = 0; got = 16'h0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (rdy[1] == 1'b0) low++;
            if (ov[1]) begin
                vcnt++;
                if (vidx == 0) begin
                    vidx = i;
                    got  = ans4;
                end
            end
            if (i == 1) begin
                a_in = 32'h1111; b_in = 32'h1111; vld[1] = 1'b1;
            end
            if (i == 2) begin
                check("ignore/ans_held", {16'd0, ans4}, 32'h0101);
                vld[1] = 1'b0;
            end
        end
        check("ignore/ready_low", 32'(low), 32'd5);
        check("ignore/valid_count", 32'(vcnt), 32'd1);
        check("ignore/valid_cycle", 32'(vidx), 32'd5);
        check("ignore/ans", {16'd0, got}, 32'h6912);

        // Back-to-back requests
        do_op(1, 32'h9999, 32'h9999, 1'b0, 1'b1, 32'h9999, 1'b1, 1'b0, "d4_b2b_a");
        do_op(1, 32'h0000, 32'h00F0, 1'b1, 1'b0, 32'h0010, 1'b1, 1'b1, "d4_b2b_errB");

        // Reset two cycles into RUN abandons the operation
        @(negedge clk);
        a_in = 32'h1234; b_in = 32'h5678; sub_in = 1'b0; cin_in = 1'b0; vld[1] = 1'b1;
        @(posedge clk);
        #1;
        vld[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst/ready", {31'd0, rdy[1]}, 32'd1);
        check("midrst/ans", {16'd0, ans4}, 32'h0);
        check("midrst/carry_err", {30'd0, cy[1], er[1]}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ov[1]) vcnt++;
        end
        check("midrst/no_valid", 32'(vcnt), 32'd0);
        do_op(1, 32'h1234, 32'h5678, 1'b0, 1'b0, 32'h6912, 1'b0, 1'b0, "d4_after_rst");

        // DIGITS=1
        do_op(0, 32'h4, 32'h5, 1'b0, 1'b0, 32'h9, 1'b0, 1'b0, "d1_add");
        do_op(0, 32'h9, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, "d1_wrap");
        do_op(0, 32'h5, 32'h1, 1'b1, 1'b0, 32'h4, 1'b1, 1'b0, "d1_sub");
        do_op(0, 32'h1, 32'h2, 1'b1, 1'b0, 32'h9, 1'b0, 1'b0, "d1_borrow");
        do_op(0, 32'hC, 32'h1, 1'b0, 1'b0, 32'h3, 1'b1, 1'b1, "d1_err");

        // DIGITS=8
        do_op(2, 32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0, "d8_add");
        do_op(2, 32'h99999999, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, "d8_wrap");
        do_op(2, 32'h50000000, 32'h12345678, 1'b1, 1'b0, 32'h37654322, 1'b1, 1'b0, "d8_sub");
        do_op(2, 32'h00000100, 32'h00000250, 1'b1, 1'b0, 32'h99999850, 1'b0, 1'b0, "d8_borrow");

        @(negedge clk);
        check("final/ready", {29'd0, rdy}, 32'h7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
